mmio_uart: RTL and testbench

Memory-mapped UART transmitter that responds to CDEC8 data-bus cycles at two fixed I/O addresses. It sits beside the program memory in the CPU shell: the CPU writes bytes into a TX FIFO and polls a status register, and the block serializes FIFO contents as 8N1 frames on `txd`. Its read data is registered like the memory, so the shell selects between memory `q` and this block's `q` using `sel`.

---
 rtl/mmio_uart_pkg.sv | 19 +
 rtl/mmio_uart_sync_fifo.sv | 54 +++++
 rtl/mmio_uart.sv | 149 ++++++++++++++
 tb/tb_mmio_uart.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared constants for mmio_uart: bus addresses, status bit positions and TX FSM states.
package mmio_uart_pkg;

  localparam logic [7:0] ADR_TXD  = 8'hF0;
  localparam logic [7:0] ADR_STAT = 8'hF1;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_e;

endpackage

// File: rtl/mmio_uart_sync_fifo.sv
// Synchronous show-ahead FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem_q[rdPtr_q];

  always_ff @(posedge clock) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and registered status read port.
// Define MMIO_UART_OVF_EN to build the sticky overflow flag in status bit 3.
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] adrs,
  input  logic [7:0] data,
  input  logic       wr_en,
  output logic [7:0] q,
  output logic       sel,
  output logic       txd
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  txState_e     state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]   bitIdx_q;
  logic [7:0]   shift_q;
  logic         txd_q;
  logic [7:0]   q_q, q_d;
  logic         sel_q, sel_d;

  logic       fifoPush, fifoPop, fifoFull, fifoEmpty, ovfBit;
  logic [7:0] fifoDout, status;

  assign fifoPush = wr_en && (adrs == ADR_TXD);
  assign fifoPop  = (state_q == TX_IDLE) && !fifoEmpty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (data),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

`ifdef MMIO_UART_OVF_EN
  logic ovf_q;

  // q_q[STAT_OVF] is only ever set by a status read that returned ovf=1.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (fifoPush && fifoFull) begin
      ovf_q <= 1'b1;
    end else if (q_q[STAT_OVF]) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovfBit = ovf_q;
`else
  assign ovfBit = 1'b0;
`endif

  always_comb begin
    status             = 8'h00;
    status[STAT_FULL]  = fifoFull;
    status[STAT_EMPTY] = fifoEmpty;
    status[STAT_BUSY]  = (state_q != TX_IDLE);
    status[STAT_OVF]   = ovfBit;
    q_d                = 8'h00;
    if (adrs == ADR_STAT) q_d = status;
  end

  assign sel_d = (adrs == ADR_TXD) || (adrs == ADR_STAT);

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q   <= 8'h00;
      sel_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      sel_q <= sel_d;
    end
  end

  // txd is registered: each transition loads the level of the bit that begins next.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= TX_IDLE;
      timer_q  <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          txd_q <= 1'b1;
          if (!fifoEmpty) begin
            shift_q <= fifoDout;
            timer_q <= '0;
            txd_q   <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (timer_q == TMAX) begin
            timer_q  <= '0;
            bitIdx_q <= '0;
            txd_q    <= shift_q[0];
            state_q  <= TX_DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (timer_q == TMAX) begin
            timer_q <= '0;
            if (bitIdx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              shift_q  <= shift_q >> 1;
              txd_q    <= shift_q[1];
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (timer_q == TMAX) begin
            timer_q <= '0;
            state_q <= TX_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign q   = q_q;
  assign sel = sel_q;
  assign txd = txd_q;

endmodule

// File: tb/tb_mmio_uart.sv
// Directed self-checking bench for mmio_uart with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart;

`ifdef MMIO_UART_OVF_EN
  localparam logic [7:0] OVF_BIT = 8'h08;
`else
  localparam logic [7:0] OVF_BIT = 8'h00;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] adrs;
  logic [7:0] data;
  logic       wr_en;
  wire  [7:0] q;
  wire        sel;
  wire        txd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mmio_uart #(.FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .adrs  (adrs),
    .data  (data),
    .wr_en (wr_en),
    .q     (q),
    .sel   (sel),
    .txd   (txd)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input logic w);
    adrs  = a;
    data  = d;
    wr_en = w;
    step();
  endtask

  task automatic runTo(input int target);
    while (cyc < target) step();
  endtask

  // Mid-bit samples of a frame whose start bit fell after cycle 'fall'; already-past bits are skipped.
  task automatic checkFrame(input logic [7:0] b, input int fall);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      int t;
      t = fall + 2 + 4 * i;
      if (cyc <= t) begin
        runTo(t);
        checkOutput($sformatf("frame%02h_bit%0d", b, i), {7'b0, txd}, {7'b0, bits[i]});
        if (adrs == 8'hF1) checkOutput($sformatf("frame%02h_busy%0d", b, i), {7'b0, q[2]}, 8'h01);
      end
    end
  endtask

  task automatic checkQuiet(input string tag, input int n);
    logic sawLow;
    sawLow = 1'b0;
    repeat (n) begin
      step();
      if (txd !== 1'b1) sawLow = 1'b1;
    end
    checkOutput(tag, {7'b0, sawLow}, 8'h00);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int fall;
    logic [7:0] vals [5];

    reset = 1'b1; adrs = 8'h00; data = 8'h00; wr_en = 1'b0;
    step();
    step();
    checkOutput("rst_txd", {7'b0, txd}, 8'h01);
    checkOutput("rst_q", q, 8'h00);
    checkOutput("rst_sel", {7'b0, sel}, 8'h00);
    reset = 1'b0;
    applyStimulus(8'hF1, 8'h00, 1'b0);
    checkOutput("stat_idle", q, 8'h02);
    checkOutput("stat_sel", {7'b0, sel}, 8'h01);

    // Single frame 0xA5
    applyStimulus(8'hF0, 8'hA5, 1'b1);
    fall = cyc + 1;
    checkOutput("a5_txd_before_pop", {7'b0, txd}, 8'h01);
    applyStimulus(8'hF1, 8'h00, 1'b0);
    checkOutput("a5_fall", {7'b0, txd}, 8'h00);
    checkFrame(8'hA5, fall);
    runTo(fall + 41);
    checkOutput("a5_done_stat", q, 8'h02);

    // Three back-to-back frames
    applyStimulus(8'hF0, 8'h01, 1'b1);
    fall = cyc + 1;
    applyStimulus(8'hF0, 8'h02, 1'b1);
    checkOutput("b2b_fall1", {7'b0, txd}, 8'h00);
    applyStimulus(8'hF0, 8'h03, 1'b1);
    adrs = 8'hF1; wr_en = 1'b0;
    checkFrame(8'h01, fall);
    for (int j = 1; j < 3; j++) begin
      runTo(fall + 40);
      checkOutput($sformatf("b2b_gap_txd%0d", j), {7'b0, txd}, 8'h01);
      runTo(fall + 41);
      checkOutput($sformatf("b2b_gap_stat%0d", j), q, 8'h00);
      fall = fall + 41;
      checkOutput($sformatf("b2b_fall%0d", j + 1), {7'b0, txd}, 8'h00);
      checkFrame(8'(j + 1), fall);
    end
    runTo(fall + 41);
    checkOutput("b2b_done_stat", q, 8'h02);

    // Five writes from idle: first pop makes room, all five accepted
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    applyStimulus(8'hF0, vals[0], 1'b1);
    fall = cyc + 1;
    for (int j = 1; j < 5; j++) applyStimulus(8'hF0, vals[j], 1'b1);
    applyStimulus(8'hF1, 8'h00, 1'b0);
    checkOutput("burst_full_stat", q, 8'h05);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        runTo(fall + 41);
        fall = fall + 41;
        checkOutput($sformatf("burst_fall%0d", j), {7'b0, txd}, 8'h00);
      end
      checkFrame(vals[j], fall);
    end
    runTo(fall + 41);
    checkOutput("burst_done_stat", q, 8'h02);

    // Five writes while busy with an empty FIFO: the fifth (0x75) is dropped
    applyStimulus(8'hF0, 8'h66, 1'b1);
    fall = cyc + 1;
    applyStimulus(8'hF1, 8'h00, 1'b0);
    for (int j = 1; j < 6; j++) applyStimulus(8'hF0, 8'(8'h70 + j), 1'b1);
    applyStimulus(8'hF1, 8'h00, 1'b0);
    checkOutput("drop_stat", q, 8'h05 | OVF_BIT);
    step();
    step();
    checkOutput("drop_ovf_cleared", q, 8'h05);
    checkFrame(8'h66, fall);
    for (int j = 1; j < 5; j++) begin
      runTo(fall + 41);
      fall = fall + 41;
      checkOutput($sformatf("drop_fall%0d", j), {7'b0, txd}, 8'h00);
      checkFrame(8'(8'h70 + j), fall);
    end
    runTo(fall + 41);
    checkOutput("drop_done_stat", q, 8'h02);
    checkQuiet("drop_no_extra_frame", 60);

    // Reset in the middle of data bit 3
    applyStimulus(8'hF0, 8'hA5, 1'b1);
    fall = cyc + 1;
    applyStimulus(8'hF0, 8'hC3, 1'b1);
    adrs = 8'hF1; wr_en = 1'b0;
    runTo(fall + 17);
    checkOutput("rstmid_bit3", {7'b0, txd}, 8'h00);
    reset = 1'b1;
    step();
    checkOutput("rstmid_txd", {7'b0, txd}, 8'h01);
    reset = 1'b0;
    step();
    checkOutput("rstmid_stat", q, 8'h02);
    checkQuiet("rstmid_no_frames", 60);

    // Unmapped read, ignored status write, TXD read
    applyStimulus(8'h10, 8'h00, 1'b0);
    checkOutput("unmapped_sel", {7'b0, sel}, 8'h00);
    checkOutput("unmapped_q", q, 8'h00);
    applyStimulus(8'hF1, 8'h77, 1'b1);
    checkOutput("wrstat_q", q, 8'h02);
    applyStimulus(8'hF1, 8'h00, 1'b0);
    checkOutput("wrstat_ignored", q, 8'h02);
    applyStimulus(8'hF0, 8'h00, 1'b0);
    checkOutput("txd_read_q", q, 8'h00);
    checkOutput("txd_read_sel", {7'b0, sel}, 8'h01);
    checkQuiet("wrstat_no_frame", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
